// File: rtl/lsu_mem_master_if.sv
// Bundles the pipeline request/response handshake and the word-addressed
// request/grant/rvalid memory bus driven by lsu_mem_master.
interface lsu_mem_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_load;
  logic        req_store;
  logic [1:0]  req_dw;
  logic        req_sign;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_data;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    input  req_valid, req_load, req_store, req_dw, req_sign, req_addr, req_wdata,
    output req_ready,
    output rsp_valid, rsp_err, rsp_data,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    output req_valid, req_load, req_store, req_dw, req_sign, req_addr, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_err, rsp_data,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/lsu_mem_master.sv
// Load/store initiator: accepts one access per handshake, runs it on the
// request/grant/rvalid memory bus and returns one (possibly error) response.
module lsu_mem_master #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  lsu_mem_master_if.master bus
);

  localparam int unsigned       CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Direction must be exactly one of load/store and the offset must suit the width.
  function automatic logic is_illegal(input logic ld, input logic st,
                                      input logic [1:0] dw, input logic [1:0] off);
    logic bad;
    bad = (ld == st);
    case (dw)
      2'd0:    bad = bad;
      2'd1:    bad = bad | off[0];
      2'd2:    bad = bad | (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] byte_enable(input logic [1:0] dw, input logic [1:0] off);
    logic [3:0] be;
    case (dw)
      2'd0:    be = 4'b0001 << off;
      2'd1:    be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [1:0] dw, input logic [31:0] wdata);
    logic [31:0] lanes;
    case (dw)
      2'd0:    lanes = {4{wdata[7:0]}};
      2'd1:    lanes = {2{wdata[15:0]}};
      default: lanes = wdata;
    endcase
    return lanes;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] rdata, input logic [1:0] dw,
                                              input logic [1:0] off, input logic sgn);
    logic [31:0] lane;
    logic [31:0] result;
    lane = rdata >> {off, 3'b000};
    case (dw)
      2'd0:    result = {{24{sgn & lane[7]}}, lane[7:0]};
      2'd1:    result = {{16{sgn & lane[15]}}, lane[15:0]};
      default: result = rdata;
    endcase
    return result;
  endfunction

  state_t            state_r;
  state_t            next_state_s;
  logic [CNT_W-1:0]  cnt_r;
  logic              load_r;
  logic [1:0]        dw_r;
  logic              sign_r;
  logic [1:0]        off_r;

  logic              rsp_valid_r;
  logic              rsp_err_r;
  logic [31:0]       rsp_data_r;
  logic              mem_req_r;
  logic              mem_we_r;
  logic [31:0]       mem_addr_r;
  logic [3:0]        mem_be_r;
  logic [31:0]       mem_wdata_r;

  logic              done_err_s;
  logic [31:0]       done_data_s;
  logic              illegal_s;

  assign illegal_s = is_illegal(bus.req_load, bus.req_store, bus.req_dw, bus.req_addr[1:0]);

  // Next-state and completion status; rvalid wins over a timeout in the same cycle.
  always_comb begin
    next_state_s = state_r;
    done_err_s   = 1'b0;
    done_data_s  = 32'h0000_0000;
    case (state_r)
      IDLE: begin
        if (bus.req_valid) begin
          if (illegal_s) begin
            next_state_s = DONE;
            done_err_s   = 1'b1;
          end else begin
            next_state_s = ISSUE;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      ISSUE: begin
        if (bus.mem_gnt) begin
          if (load_r) begin
            next_state_s = WAIT;
          end else begin
            next_state_s = DONE;
          end
        end else begin
          next_state_s = ISSUE;
        end
      end
      WAIT: begin
        if (bus.mem_rvalid) begin
          next_state_s = DONE;
          done_data_s  = load_extend(bus.mem_rdata, dw_r, off_r, sign_r);
        end else if (cnt_r == CNT_LAST) begin
          next_state_s = DONE;
          done_err_s   = 1'b1;
        end else begin
          next_state_s = WAIT;
        end
      end
      DONE: begin
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State, timeout counter, latched request and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      load_r      <= 1'b0;
      dw_r        <= 2'b00;
      sign_r      <= 1'b0;
      off_r       <= 2'b00;
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_data_r  <= 32'h0000_0000;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= 32'h0000_0000;
      mem_be_r    <= 4'b0000;
      mem_wdata_r <= 32'h0000_0000;
    end else begin
      state_r     <= next_state_s;
      rsp_valid_r <= (next_state_s == DONE);
      mem_req_r   <= (next_state_s == ISSUE);

      // Bus fields are captured once at accept and stay put until the grant.
      if ((state_r == IDLE) && (next_state_s == ISSUE)) begin
        load_r      <= bus.req_load;
        dw_r        <= bus.req_dw;
        sign_r      <= bus.req_sign;
        off_r       <= bus.req_addr[1:0];
        mem_we_r    <= bus.req_store;
        mem_addr_r  <= {bus.req_addr[31:2], 2'b00};
        mem_be_r    <= byte_enable(bus.req_dw, bus.req_addr[1:0]);
        mem_wdata_r <= store_lanes(bus.req_dw, bus.req_wdata);
      end

      if (state_r == ISSUE) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (state_r == WAIT) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end

      if (next_state_s == DONE) begin
        rsp_err_r  <= done_err_s;
        rsp_data_r <= done_data_s;
      end
    end
  end

  assign bus.req_ready = (state_r == IDLE) && rst_n;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_err   = rsp_err_r;
  assign bus.rsp_data  = rsp_data_r;
  assign bus.mem_req   = mem_req_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_be    = mem_be_r;
  assign bus.mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master: inputs change and outputs are checked on the falling edge.
module tb_lsu_mem_master;
  localparam int T = 16;

  logic clk;
  logic rst_n;
  int   checks;
  int   passes;
  int   fails;

  lsu_mem_master_if bus ();

  lsu_mem_master #(.TIMEOUT_CYCLES(T)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic ld, input logic st, input logic [1:0] dw, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata);
    chk("accept_ready", {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1;
    bus.req_load  = ld;
    bus.req_store = st;
    bus.req_dw    = dw;
    bus.req_sign  = sgn;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic check_bus(input logic we, input logic [31:0] addr, input logic [3:0] be);
    chk("issue_req",   {31'd0, bus.mem_req},   32'd1);
    chk("issue_we",    {31'd0, bus.mem_we},    {31'd0, we});
    chk("issue_addr",  bus.mem_addr,           addr);
    chk("issue_be",    {28'd0, bus.mem_be},    {28'd0, be});
    chk("issue_ready", {31'd0, bus.req_ready}, 32'd0);
    chk("issue_rsp",   {31'd0, bus.rsp_valid}, 32'd0);
  endtask

  task automatic grant(input logic noise);
    bus.mem_gnt = 1'b1;
    if (noise) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'h5A5A_5A5A;
    end
    @(negedge clk);
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
  endtask

  task automatic expect_rsp(input logic err, input logic [31:0] data);
    chk("rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    chk("rsp_err",   {31'd0, bus.rsp_err},   {31'd0, err});
    chk("rsp_data",  bus.rsp_data,           data);
    chk("done_ready", {31'd0, bus.req_ready}, 32'd0);
    chk("done_req",  {31'd0, bus.mem_req},   32'd0);
    @(negedge clk);
    chk("rsp_pulse", {31'd0, bus.rsp_valid}, 32'd0);
    chk("idle_ready", {31'd0, bus.req_ready}, 32'd1);
  endtask

  task automatic run_store(input logic [1:0] dw, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_addr, input logic [3:0] exp_be,
                           input logic [31:0] exp_wdata, input int stall);
    accept(1'b0, 1'b1, dw, 1'b0, addr, wdata);
    for (int i = 0; i < stall; i++) begin
      check_bus(1'b1, exp_addr, exp_be);
      chk("store_wdata", bus.mem_wdata, exp_wdata);
      @(negedge clk);
    end
    check_bus(1'b1, exp_addr, exp_be);
    chk("store_wdata", bus.mem_wdata, exp_wdata);
    grant(1'b0);
    expect_rsp(1'b0, 32'h0000_0000);
  endtask

  task automatic run_load(input logic [1:0] dw, input logic sgn, input logic [31:0] addr,
                          input logic [31:0] rdata, input logic [31:0] exp_addr,
                          input logic [3:0] exp_be, input logic [31:0] exp_data,
                          input int stall, input int wait_cycles, input logic noise);
    accept(1'b1, 1'b0, dw, sgn, addr, 32'hFFFF_FFFF);
    for (int i = 0; i < stall; i++) begin
      check_bus(1'b0, exp_addr, exp_be);
      @(negedge clk);
    end
    check_bus(1'b0, exp_addr, exp_be);
    grant(noise);
    for (int i = 0; i < wait_cycles; i++) begin
      chk("wait_req", {31'd0, bus.mem_req},   32'd0);
      chk("wait_rsp", {31'd0, bus.rsp_valid}, 32'd0);
      @(negedge clk);
    end
    if (wait_cycles < T) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = rdata;
      @(negedge clk);
      bus.mem_rvalid = 1'b0;
      expect_rsp(1'b0, exp_data);
    end else begin
      expect_rsp(1'b1, 32'h0000_0000);
    end
  endtask

  task automatic run_error(input logic ld, input logic st, input logic [1:0] dw,
                           input logic [31:0] addr);
    accept(ld, st, dw, 1'b1, addr, 32'h1234_5678);
    expect_rsp(1'b1, 32'h0000_0000);
  endtask

  initial begin
    checks = 0;
    passes = 0;
    fails  = 0;
    rst_n          = 1'b0;
    bus.req_valid  = 1'b1;
    bus.req_load   = 1'b0;
    bus.req_store  = 1'b1;
    bus.req_dw     = 2'd2;
    bus.req_sign   = 1'b0;
    bus.req_addr   = 32'h0000_0000;
    bus.req_wdata  = 32'h0000_0000;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0000_0000;

    // Reset held three cycles with a request pending.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_ready", {31'd0, bus.req_ready}, 32'd0);
      chk("rst_req",   {31'd0, bus.mem_req},   32'd0);
      chk("rst_rsp",   {31'd0, bus.rsp_valid}, 32'd0);
    end
    chk("rst_err",   {31'd0, bus.rsp_err}, 32'd0);
    chk("rst_data",  bus.rsp_data,         32'd0);
    chk("rst_we",    {31'd0, bus.mem_we},  32'd0);
    chk("rst_addr",  bus.mem_addr,         32'd0);
    chk("rst_be",    {28'd0, bus.mem_be},  32'd0);
    chk("rst_wdata", bus.mem_wdata,        32'd0);
    rst_n         = 1'b1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, bus.req_ready}, 32'd1);

    // Stores: lane replication and byte enables, one with a grant stall.
    run_store(2'd0, 32'h0000_0103, 32'h0000_00A5, 32'h0000_0100, 4'b1000, 32'hA5A5_A5A5, 0);
    run_store(2'd1, 32'h0000_0106, 32'h1234_ABCD, 32'h0000_0104, 4'b1100, 32'hABCD_ABCD, 0);
    run_store(2'd2, 32'h0000_0008, 32'hCAFE_F00D, 32'h0000_0008, 4'b1111, 32'hCAFE_F00D, 2);

    // Loads: rvalid during ISSUE is ignored on the first one.
    run_load(2'd1, 1'b1, 32'h0000_0022, 32'h8001_0000, 32'h0000_0020, 4'b1100, 32'hFFFF_8001, 0, 0, 1'b1);
    run_load(2'd1, 1'b0, 32'h0000_0022, 32'h8001_0000, 32'h0000_0020, 4'b1100, 32'h0000_8001, 0, 0, 1'b0);
    run_load(2'd0, 1'b1, 32'h0000_0101, 32'h1234_F056, 32'h0000_0100, 4'b0010, 32'hFFFF_FFF0, 0, 0, 1'b0);
    run_load(2'd2, 1'b1, 32'h0000_0200, 32'hDEAD_BEEF, 32'h0000_0200, 4'b1111, 32'hDEAD_BEEF, 0, 0, 1'b0);

    // Errors complete in one cycle with no bus request and zero data.
    run_error(1'b1, 1'b0, 2'd2, 32'h0000_0006);
    run_error(1'b1, 1'b0, 2'd3, 32'h0000_0000);
    run_error(1'b1, 1'b1, 2'd0, 32'h0000_0010);
    run_error(1'b0, 1'b0, 2'd0, 32'h0000_0010);
    run_error(1'b0, 1'b1, 2'd1, 32'h0000_0003);

    // Grant stall then timeout; then rvalid on the last WAIT cycle.
    run_load(2'd2, 1'b0, 32'h0000_0040, 32'h0000_0000, 32'h0000_0040, 4'b1111, 32'h0000_0000, 5, T, 1'b0);
    run_load(2'd0, 1'b0, 32'h0000_0043, 32'h9A00_0000, 32'h0000_0040, 4'b1000, 32'h0000_009A, 0, T - 1, 1'b0);

    // Reset in WAIT, late rvalid ignored, then a normal store.
    accept(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0080, 32'h0000_0000);
    check_bus(1'b0, 32'h0000_0080, 4'b1111);
    grant(1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_ready", {31'd0, bus.req_ready}, 32'd0);
    chk("midrst_rsp",   {31'd0, bus.rsp_valid}, 32'd0);
    chk("midrst_req",   {31'd0, bus.mem_req},   32'd0);
    rst_n          = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h1111_2222;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    chk("late_rvalid_rsp", {31'd0, bus.rsp_valid}, 32'd0);
    @(negedge clk);
    chk("late_rvalid_rsp2", {31'd0, bus.rsp_valid}, 32'd0);
    run_store(2'd2, 32'h0000_0084, 32'h0BAD_F00D, 32'h0000_0084, 4'b1111, 32'h0BAD_F00D, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
